// File: rtl/motor_pkg.sv
// Shared encodings for the motor drive controller: steering fields, H-bridge
// polarity, FSM states and the decoded command record.
package motor_pkg;

  typedef enum logic [1:0] {
    ACT_PROCEED = 2'b00,
    ACT_LEFT    = 2'b01,
    ACT_RIGHT   = 2'b10,
    ACT_STOP    = 2'b11
  } act_e;

  typedef enum logic [1:0] {
    MAG_FULL   = 2'b00,
    MAG_VEER   = 2'b01,
    MAG_HARD   = 2'b10,
    MAG_NINETY = 2'b11
  } mag_e;

  typedef enum logic [1:0] {
    POL_COAST = 2'b00,
    POL_REV   = 2'b01,
    POL_FWD   = 2'b10,
    POL_BRAKE = 2'b11
  } pol_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DEAD,
    S_PIVOT
  } state_e;

  // Speed class per wheel; the top maps classes onto its duty parameters.
  typedef enum logic [1:0] {
    SPD_ZERO,
    SPD_FULL,
    SPD_VEER,
    SPD_HARD
  } spd_e;

  typedef struct packed {
    spd_e spd_l;
    spd_e spd_r;
    pol_e pol_l;
    pol_e pol_r;
    logic stop;
    logic ninety;
  } cmd_t;

  function automatic cmd_t decode_cmd(input logic [3:0] dir, input logic fwd);
    cmd_t c;
    pol_e trav;
    pol_e anti;
    trav     = fwd ? POL_FWD : POL_REV;
    anti     = fwd ? POL_REV : POL_FWD;
    c.spd_l  = SPD_FULL;
    c.spd_r  = SPD_FULL;
    c.pol_l  = trav;
    c.pol_r  = trav;
    c.stop   = 1'b0;
    c.ninety = 1'b0;
    case (act_e'(dir[3:2]))
      ACT_STOP: begin
        c.spd_l = SPD_ZERO;
        c.spd_r = SPD_ZERO;
        c.pol_l = POL_BRAKE;
        c.pol_r = POL_BRAKE;
        c.stop  = 1'b1;
      end
      ACT_LEFT: begin
        case (mag_e'(dir[1:0]))
          MAG_VEER:   c.spd_l = SPD_VEER;
          MAG_HARD:   c.spd_l = SPD_HARD;
          MAG_NINETY: begin
            c.pol_l  = anti;
            c.ninety = 1'b1;
          end
          default: ;
        endcase
      end
      ACT_RIGHT: begin
        case (mag_e'(dir[1:0]))
          MAG_VEER:   c.spd_r = SPD_VEER;
          MAG_HARD:   c.spd_r = SPD_HARD;
          MAG_NINETY: begin
            c.pol_r  = anti;
            c.ninety = 1'b1;
          end
          default: ;
        endcase
      end
      default: ;  // every proceed code, defined or not, drives straight ahead
    endcase
    return c;
  endfunction

  // Only a direct fwd<->rev swap needs dead time; leaving coast/brake does not.
  function automatic logic is_reversal(input pol_e cur, input pol_e nxt);
    return ((cur == POL_FWD) && (nxt == POL_REV)) ||
           ((cur == POL_REV) && (nxt == POL_FWD));
  endfunction

endpackage

// File: rtl/pwm_ramp_channel.sv
// One motor's PWM channel: ramps its duty toward a target once per PWM period
// and compares against the shared period counter.
module pwm_ramp_channel #(
  parameter int DW        = 12,
  parameter int RAMP_STEP = 100
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [DW-1:0] duty_tgt,
  input  logic [DW-1:0] cnt,
  input  logic          step_en,
  input  logic          force_zero,
  output logic          pwm
);

  localparam logic [DW-1:0] STEP = DW'(RAMP_STEP);

  logic [DW-1:0] duty_cur;
  logic [DW-1:0] duty_nx;

  // NOTE: combinational blocks assign every output a default first, so no path
  // through the if/else can leave a value held and infer a latch.
  always_comb begin
    duty_nx = duty_cur;
    if (duty_cur < duty_tgt) begin
      duty_nx = ((duty_tgt - duty_cur) > STEP) ? (duty_cur + STEP) : duty_tgt;
    end else if (duty_cur > duty_tgt) begin
      duty_nx = ((duty_cur - duty_tgt) > STEP) ? (duty_cur - STEP) : duty_tgt;
    end
  end

  // NOTE: state uses non-blocking assignments and an asynchronous active-low
  // reset, so outputs drop the moment rst_n falls, independent of clk.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      duty_cur <= '0;
      pwm      <= 1'b0;
    end else if (force_zero) begin
      duty_cur <= '0;
      pwm      <= 1'b0;
    end else begin
      if (step_en) duty_cur <= duty_nx;
      pwm <= (cnt < duty_cur);
    end
  end

endmodule

// File: rtl/motor_drive_ctrl.sv
// Steering-command to H-bridge controller: input registers, shared PWM
// counter, IDLE/RUN/DEAD/PIVOT sequencing and the per-command target table.
module motor_drive_ctrl
  import motor_pkg::*;
#(
  parameter int PWM_PERIOD = 2500,
  parameter int DUTY_FULL  = 2400,
  parameter int DUTY_VEER  = 1600,
  parameter int DUTY_HARD  = 800,
  parameter int RAMP_STEP  = 100,
  parameter int DEAD_TIME  = 50_000,
  parameter int PIVOT_TIME = 25_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       direction,
  input  logic [3:0] dir,
  output logic       pwm_l,
  output logic       pwm_r,
  output logic [1:0] pol_l,
  output logic [1:0] pol_r,
  output logic       busy
);

  localparam int DW  = $clog2(PWM_PERIOD + 1);
  localparam int DTW = $clog2(DEAD_TIME + 1);
  localparam int PTW = $clog2(PIVOT_TIME + 1);

  logic [3:0]     dir_q;
  logic           direction_q;
  logic [DW-1:0]  cnt;
  logic           wrap;

  state_e         state, state_nx;
  pol_e           pol_l_q, pol_r_q, pol_l_nx, pol_r_nx;
  pol_e           pend_pol_l, pend_pol_r;
  spd_e           pend_spd_l, pend_spd_r;
  logic           pend_ninety, pend_ld;
  logic           spent, spent_set;
  logic [DTW-1:0] dead_cnt;
  logic [PTW-1:0] piv_cnt;
  logic           dead_done, piv_done;

  cmd_t           cmd;
  logic           flip_l, flip_r;
  spd_e           spd_l_sel, spd_r_sel;
  logic [DW-1:0]  duty_tgt_l, duty_tgt_r;
  logic           force_zero, step_en;

  function automatic logic [DW-1:0] spd2duty(input spd_e s);
    case (s)
      SPD_FULL: return DW'(DUTY_FULL);
      SPD_VEER: return DW'(DUTY_VEER);
      SPD_HARD: return DW'(DUTY_HARD);
      default:  return '0;
    endcase
  endfunction

  // Inputs come up as STOP so the first post-reset cycle never drives forward.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dir_q       <= 4'b1111;
      direction_q <= 1'b1;
    end else begin
      dir_q       <= dir;
      direction_q <= direction;
    end
  end

  assign wrap = (cnt == DW'(PWM_PERIOD - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt <= '0;
    else        cnt <= wrap ? '0 : cnt + 1'b1;
  end

  always_comb begin
    cmd    = decode_cmd(dir_q, direction_q);
    flip_l = is_reversal(pol_l_q, cmd.pol_l);
    flip_r = is_reversal(pol_r_q, cmd.pol_r);
  end

  assign dead_done = (dead_cnt >= DTW'(DEAD_TIME - 1));
  assign piv_done  = (piv_cnt  >= PTW'(PIVOT_TIME - 1));

  always_comb begin
    state_nx  = state;
    pol_l_nx  = pol_l_q;
    pol_r_nx  = pol_r_q;
    pend_ld   = 1'b0;
    spent_set = 1'b0;
    if (cmd.stop) begin
      state_nx = S_IDLE;
      pol_l_nx = POL_BRAKE;
      pol_r_nx = POL_BRAKE;
    end else begin
      case (state)
        S_IDLE: begin
          state_nx = S_RUN;
          pol_l_nx = cmd.pol_l;
          pol_r_nx = cmd.pol_r;
        end
        S_RUN: begin
          if (flip_l || flip_r) begin
            state_nx = S_DEAD;
            pend_ld  = 1'b1;
            pol_l_nx = flip_l ? POL_COAST : pol_l_q;
            pol_r_nx = flip_r ? POL_COAST : pol_r_q;
          end else begin
            pol_l_nx = cmd.pol_l;
            pol_r_nx = cmd.pol_r;
            // A pivot already served for this held command is not repeated.
            if (cmd.ninety && !spent) begin
              state_nx = S_PIVOT;
              pend_ld  = 1'b1;
            end
          end
        end
        S_DEAD: begin
          if (dead_done) begin
            state_nx = pend_ninety ? S_PIVOT : S_RUN;
            pol_l_nx = pend_pol_l;
            pol_r_nx = pend_pol_r;
          end
        end
        S_PIVOT: begin
          if (piv_done) begin
            state_nx  = S_RUN;
            spent_set = 1'b1;
          end
        end
        default: state_nx = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      pol_l_q     <= POL_COAST;
      pol_r_q     <= POL_COAST;
      pend_pol_l  <= POL_COAST;
      pend_pol_r  <= POL_COAST;
      pend_spd_l  <= SPD_ZERO;
      pend_spd_r  <= SPD_ZERO;
      pend_ninety <= 1'b0;
      spent       <= 1'b0;
      dead_cnt    <= '0;
      piv_cnt     <= '0;
    end else begin
      state   <= state_nx;
      pol_l_q <= pol_l_nx;
      pol_r_q <= pol_r_nx;
      if (pend_ld) begin
        pend_pol_l  <= cmd.pol_l;
        pend_pol_r  <= cmd.pol_r;
        pend_spd_l  <= cmd.spd_l;
        pend_spd_r  <= cmd.spd_r;
        pend_ninety <= cmd.ninety;
      end
      if ((state_nx == S_IDLE) || (state_nx == S_DEAD)) spent <= 1'b0;
      else if (spent_set)                               spent <= 1'b1;
      else if ((state == S_RUN) && !cmd.ninety)         spent <= 1'b0;
      if ((state == S_DEAD) && (state_nx == S_DEAD) && !dead_done) dead_cnt <= dead_cnt + 1'b1;
      else                                                         dead_cnt <= '0;
      if ((state == S_PIVOT) && (state_nx == S_PIVOT) && !piv_done) piv_cnt <= piv_cnt + 1'b1;
      else                                                          piv_cnt <= '0;
    end
  end

  // Pivot holds the targets captured at entry; RUN follows the live command.
  assign spd_l_sel  = (state == S_PIVOT) ? pend_spd_l : cmd.spd_l;
  assign spd_r_sel  = (state == S_PIVOT) ? pend_spd_r : cmd.spd_r;
  assign duty_tgt_l = spd2duty(spd_l_sel);
  assign duty_tgt_r = spd2duty(spd_r_sel);
  assign force_zero = (state_nx == S_IDLE) || (state_nx == S_DEAD);
  assign step_en    = wrap && (state_nx == state);

  pwm_ramp_channel #(.DW(DW), .RAMP_STEP(RAMP_STEP)) u_ch_l (
    .clk        (clk),
    .rst_n      (rst_n),
    .duty_tgt   (duty_tgt_l),
    .cnt        (cnt),
    .step_en    (step_en),
    .force_zero (force_zero),
    .pwm        (pwm_l)
  );

  pwm_ramp_channel #(.DW(DW), .RAMP_STEP(RAMP_STEP)) u_ch_r (
    .clk        (clk),
    .rst_n      (rst_n),
    .duty_tgt   (duty_tgt_r),
    .cnt        (cnt),
    .step_en    (step_en),
    .force_zero (force_zero),
    .pwm        (pwm_r)
  );

  assign pol_l = pol_l_q;
  assign pol_r = pol_r_q;
  assign busy  = (state == S_DEAD) || (state == S_PIVOT);

endmodule

// File: tb/tb_motor_drive_ctrl.sv
// Bench for motor_drive_ctrl with shortened timing: directed scenarios plus
// random commands checked against a rule-level model of settled outputs.
module tb_motor_drive_ctrl;

  localparam int P    = 100;
  localparam int FULL = 90;
  localparam int VEER = 60;
  localparam int HARD = 30;
  localparam int STEP = 10;
  localparam int DT   = 20;
  localparam int PT   = 500;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       direction = 1'b1;
  logic [3:0] dir = 4'b0000;
  logic       pwm_l, pwm_r;
  logic [1:0] pol_l, pol_r;
  logic       busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  motor_drive_ctrl #(
    .PWM_PERIOD (P),
    .DUTY_FULL  (FULL),
    .DUTY_VEER  (VEER),
    .DUTY_HARD  (HARD),
    .RAMP_STEP  (STEP),
    .DEAD_TIME  (DT),
    .PIVOT_TIME (PT)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .direction (direction),
    .dir       (dir),
    .pwm_l     (pwm_l),
    .pwm_r     (pwm_r),
    .pol_l     (pol_l),
    .pol_r     (pol_r),
    .busy      (busy)
  );

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Settled behaviour straight from the command rules: pol 2=fwd 1=rev 3=brake.
  task automatic ref_cmd(input logic [3:0] d, input logic fwd,
                         output int dl, output int dr, output int pl, output int pr);
    int steer, mag, trav, anti, inner;
    steer = int'(d[3:2]);
    mag   = int'(d[1:0]);
    trav  = fwd ? 2 : 1;
    anti  = fwd ? 1 : 2;
    inner = (mag == 1) ? VEER : (mag == 2) ? HARD : FULL;
    if (steer == 3) begin
      dl = 0; dr = 0; pl = 3; pr = 3;
    end else begin
      dl = FULL; dr = FULL; pl = trav; pr = trav;
      if (steer == 1) begin
        if (mag == 3) pl = anti; else dl = inner;
      end
      if (steer == 2) begin
        if (mag == 3) pr = anti; else dr = inner;
      end
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_rise_l(output int ok);
    int n;
    n = 0;
    while (pwm_l !== 1'b0 && n < 1000) begin @(negedge clk); n++; end
    while (pwm_l !== 1'b1 && n < 1000) begin @(negedge clk); n++; end
    ok = (pwm_l === 1'b1) ? 1 : 0;
  endtask

  task automatic wait_busy(input logic lvl, input int budget, output int ok);
    int n;
    n = 0;
    while (busy !== lvl && n < budget) begin @(negedge clk); n++; end
    ok = (busy === lvl) ? 1 : 0;
  endtask

  // High-cycle count over one PWM period, starting at the current sample.
  task automatic count_window(output int hl, output int hr);
    hl = 0;
    hr = 0;
    for (int i = 0; i < P; i++) begin
      hl += int'(pwm_l);
      hr += int'(pwm_r);
      @(negedge clk);
    end
  endtask

  task automatic ramp_up_check(input string tag);
    int ok, hl, hr, e;
    tick(3);
    check({tag, "_pol_l"}, int'(pol_l), 2);
    check({tag, "_pol_r"}, int'(pol_r), 2);
    wait_rise_l(ok);
    check({tag, "_rise"}, ok, 1);
    for (int k = 1; k <= 10; k++) begin
      count_window(hl, hr);
      e = (k * STEP > FULL) ? FULL : k * STEP;
      check($sformatf("%s_duty_l_p%0d", tag, k), hl, e);
      check($sformatf("%s_duty_r_p%0d", tag, k), hr, e);
    end
  endtask

  initial begin
    int ok, hl, hr, n, bad_pwm, bad_pol, hi;
    int dl, dr, pl, pr;
    logic [3:0] rd;
    logic rf;

    // Reset state
    tick(2);
    #1;
    check("rst_pwm_l", int'(pwm_l), 0);
    check("rst_pwm_r", int'(pwm_r), 0);
    check("rst_pol_l", int'(pol_l), 0);
    check("rst_pol_r", int'(pol_r), 0);
    check("rst_busy",  int'(busy),  0);
    @(negedge clk);
    dir = 4'b0000; direction = 1'b1; rst_n = 1'b1;

    // 1: ramp from zero to full
    ramp_up_check("t1");

    // 2: veer left ramps only the left wheel down
    wait_rise_l(ok);
    check("t2_rise", ok, 1);
    dir = 4'b0101;
    for (int k = 0; k < 5; k++) begin
      count_window(hl, hr);
      check($sformatf("t2_duty_l_p%0d", k), hl, (k >= 3) ? VEER : FULL - k * STEP);
      check($sformatf("t2_duty_r_p%0d", k), hr, FULL);
    end
    check("t2_busy",  int'(busy),  0);
    check("t2_pol_l", int'(pol_l), 2);
    check("t2_pol_r", int'(pol_r), 2);

    // 3: ninety-left from proceed: dead time on the left, then pivot
    dir = 4'b0000;
    tick(500);
    dir = 4'b0111;
    wait_busy(1'b1, 10, ok);
    check("t3_busy_rise", ok, 1);
    n = 0; bad_pwm = 0; bad_pol = 0;
    while (pol_l === 2'b00 && n < 100) begin
      if (pwm_l || pwm_r) bad_pwm++;
      if (pol_r !== 2'b10 || busy !== 1'b1) bad_pol++;
      n++;
      @(negedge clk);
    end
    check("t3_dead_len", n, DT);
    check("t3_dead_pwm", bad_pwm, 0);
    check("t3_dead_pol_r", bad_pol, 0);
    check("t3_piv_pol_l", int'(pol_l), 1);
    check("t3_piv_pol_r", int'(pol_r), 2);
    n = 0;
    while (busy === 1'b1 && n < 1000) begin n++; @(negedge clk); end
    check("t3_piv_len", n, PT);
    hi = 0;
    for (int i = 0; i < 10; i++) begin hi += int'(busy); @(negedge clk); end
    check("t3_run_busy", hi, 0);
    check("t3_run_pol_l", int'(pol_l), 1);

    // 4: stop during pivot aborts to brake one cycle after registration
    dir = 4'b0000;
    tick(100);
    dir = 4'b0111;
    wait_busy(1'b1, 10, ok);
    check("t4_busy_rise", ok, 1);
    tick(100);
    check("t4_in_pivot", int'(pol_l), 1);
    dir = 4'b1111;
    tick(2);
    check("t4_pol_l", int'(pol_l), 3);
    check("t4_pol_r", int'(pol_r), 3);
    check("t4_pwm_l", int'(pwm_l), 0);
    check("t4_pwm_r", int'(pwm_r), 0);
    check("t4_busy",  int'(busy),  0);

    // 5: travel reversal coasts both wheels; commands during dead ignored
    dir = 4'b0000; direction = 1'b1;
    tick(1200);
    direction = 1'b0;
    wait_busy(1'b1, 10, ok);
    check("t5_busy_rise", ok, 1);
    n = 0;
    while (pol_l === 2'b00 && pol_r === 2'b00 && n < 100) begin
      if (n == 5) dir = 4'b0101;
      n++;
      @(negedge clk);
    end
    check("t5_dead_len", n, DT);
    check("t5_pol_l", int'(pol_l), 1);
    check("t5_pol_r", int'(pol_r), 1);
    check("t5_busy",  int'(busy),  0);
    wait_rise_l(ok);
    check("t5_rise", ok, 1);
    for (int k = 1; k <= 3; k++) begin
      count_window(hl, hr);
      check($sformatf("t5_duty_l_p%0d", k), hl, k * STEP);
      check($sformatf("t5_duty_r_p%0d", k), hr, k * STEP);
    end

    // 6a: reset mid-ramp clears outputs at once, then behaves as after power-up
    wait_rise_l(ok);
    check("t6_rise", ok, 1);
    #2 rst_n = 1'b0;
    #1;
    check("t6a_pwm_l", int'(pwm_l), 0);
    check("t6a_pol_l", int'(pol_l), 0);
    check("t6a_pol_r", int'(pol_r), 0);
    check("t6a_busy",  int'(busy),  0);
    @(negedge clk);
    dir = 4'b0000; direction = 1'b1; rst_n = 1'b1;
    ramp_up_check("t6");

    // 6b: reset mid-dead
    dir = 4'b0111;
    wait_busy(1'b1, 10, ok);
    check("t6b_busy_rise", ok, 1);
    tick(5);
    check("t6b_pre_pol_r", int'(pol_r), 2);
    #2 rst_n = 1'b0;
    #1;
    check("t6b_pol_l", int'(pol_l), 0);
    check("t6b_pol_r", int'(pol_r), 0);
    check("t6b_pwm_r", int'(pwm_r), 0);
    check("t6b_busy",  int'(busy),  0);
    @(negedge clk);
    rst_n = 1'b1;

    // Random commands, checked once settled
    for (int it = 0; it < 8; it++) begin
      rd = 4'($urandom_range(0, 15));
      rf = 1'($urandom_range(0, 1));
      dir = rd; direction = rf;
      tick(3);
      wait_busy(1'b0, 2000, ok);
      check($sformatf("rnd%0d_settle", it), ok, 1);
      tick(1100);
      ref_cmd(rd, rf, dl, dr, pl, pr);
      check($sformatf("rnd%0d_pol_l_%b_%b", it, rd, rf), int'(pol_l), pl);
      check($sformatf("rnd%0d_pol_r_%b_%b", it, rd, rf), int'(pol_r), pr);
      if (dl == 0) begin
        count_window(hl, hr);
      end else begin
        wait_rise_l(ok);
        check($sformatf("rnd%0d_rise", it), ok, 1);
        count_window(hl, hr);
      end
      check($sformatf("rnd%0d_duty_l_%b_%b", it, rd, rf), hl, dl);
      check($sformatf("rnd%0d_duty_r_%b_%b", it, rd, rf), hr, dr);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
